// File: rtl/heap_op_scheduler.sv
// Round-robin front end that serialises push/pop/replace requests from several requesters
// onto one pipelined heap, spacing heap commands so each root sift can settle.
module heap_op_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OP_GAP     = 4
) (
   input  logic                          CLK,
   input  logic                          RSTn,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [2*NUM_REQ-1:0]          i_req_op,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
   output logic [DATA_WIDTH-1:0]         o_rsp_data,
   output logic                          o_rsp_err,
   input  logic                          i_rsp_ready,
   output logic                          o_heap_wrt,
   output logic                          o_heap_read,
   output logic [DATA_WIDTH-1:0]         o_heap_data,
   input  logic                          i_heap_full,
   input  logic                          i_heap_empty,
   input  logic [DATA_WIDTH-1:0]         i_heap_data
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned GapW = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;

   typedef enum logic [1:0] {StIdle, StExec, StResp, StGap} state_e;

   state_e                state_q, state_d;
   logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
   logic [IdW-1:0]        id_q, id_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] key_q, key_d;
   logic [IdW-1:0]        rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  pulsed_q, pulsed_d;

   logic [1:0]            req_op_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] req_key_arr [NUM_REQ];
   logic                  grant_hit;
   logic [IdW-1:0]        grant_id;
   logic [IdW-1:0]        scan_id;
   logic                  do_wrt, do_read;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_op_arr[g]  = i_req_op[2*g +: 2];
      assign req_key_arr[g] = i_req_data[DATA_WIDTH*g +: DATA_WIDTH];
   end

   // Rotating priority scan starting at rr_ptr.
   always_comb begin
      grant_hit = 1'b0;
      grant_id  = '0;
      scan_id   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_id = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!grant_hit && i_req_valid[scan_id]) begin
            grant_hit = 1'b1;
            grant_id  = scan_id;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gap_cnt_d   = gap_cnt_q;
      id_d        = id_q;
      op_d        = op_q;
      key_d       = key_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      pulsed_d    = pulsed_q;
      o_req_ready = '0;
      do_wrt      = 1'b0;
      do_read     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (grant_hit) begin
               // Gated so no grant is shown while reset is asserted.
               o_req_ready[grant_id] = RSTn;
               id_d    = grant_id;
               op_d    = req_op_arr[grant_id];
               key_d   = req_key_arr[grant_id];
               state_d = StExec;
            end
         end
         StExec: begin
            unique case (op_q)
               2'b01: do_wrt = !i_heap_full;
               2'b10: do_read = !i_heap_empty;
               2'b11: begin
                  do_wrt  = 1'b1;
                  do_read = !i_heap_empty;
               end
               2'b00: ;
            endcase
            rsp_id_d   = id_q;
            rsp_data_d = do_read ? i_heap_data : '0;
            rsp_err_d  = !(do_wrt || do_read);
            pulsed_d   = do_wrt || do_read;
            rr_ptr_d   = (id_q == IdW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state_d    = StResp;
         end
         StResp: begin
            if (i_rsp_ready) begin
               rsp_id_d   = '0;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               pulsed_d   = 1'b0;
               if (pulsed_q) begin
                  gap_cnt_d = GapW'(OP_GAP - 1);
                  state_d   = StGap;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            if (gap_cnt_q == '0) state_d = StIdle;
            else                 gap_cnt_d = gap_cnt_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   assign o_heap_wrt  = do_wrt;
   assign o_heap_read = do_read;
   assign o_heap_data = do_wrt ? key_q : '0;
   assign o_rsp_valid = (state_q == StResp);
   assign o_rsp_id    = rsp_id_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_err   = rsp_err_q;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         gap_cnt_q  <= '0;
         id_q       <= '0;
         op_q       <= '0;
         key_q      <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         pulsed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gap_cnt_q  <= gap_cnt_d;
         id_q       <= id_d;
         op_q       <= op_d;
         key_q      <= key_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         pulsed_q   <= pulsed_d;
      end
   end

endmodule

// File: tb/tb_heap_op_scheduler.sv
// Bench for heap_op_scheduler: behavioural heap, grant/pulse/response logs and a response
// scoreboard filled at grant time from the heap model.
module tb_heap_op_scheduler;

   localparam int NR  = 4;
   localparam int DW  = 16;
   localparam int GAP = 4;
   localparam int CAP = 8;

   logic            CLK = 1'b0;
   logic            RSTn;
   logic [NR-1:0]   i_req_valid;
   logic [2*NR-1:0] i_req_op;
   logic [DW*NR-1:0] i_req_data;
   logic [NR-1:0]   o_req_ready;
   logic            o_rsp_valid;
   logic [1:0]      o_rsp_id;
   logic [DW-1:0]   o_rsp_data;
   logic            o_rsp_err;
   logic            i_rsp_ready;
   logic            o_heap_wrt;
   logic            o_heap_read;
   logic [DW-1:0]   o_heap_data;
   logic            i_heap_full;
   logic            i_heap_empty;
   logic [DW-1:0]   i_heap_data;

   heap_op_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OP_GAP(GAP)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_data(i_req_data),
      .o_req_ready(o_req_ready),
      .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
      .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready),
      .o_heap_wrt(o_heap_wrt), .o_heap_read(o_heap_read), .o_heap_data(o_heap_data),
      .i_heap_full(i_heap_full), .i_heap_empty(i_heap_empty), .i_heap_data(i_heap_data)
   );

   always #5 CLK = ~CLK;

   typedef struct {int id; logic [DW-1:0] data; logic err;} exp_t;
   typedef struct {int cyc; int id;} grant_t;
   typedef struct {int cyc; logic wrt; logic rd; logic [DW-1:0] data;} pulse_t;

   exp_t   sb[$];
   grant_t glog[$];
   pulse_t plog[$];
   int     rlog[$];
   int     hq[$];
   int     cyc = 0;
   int     vectors = 0;
   int     miscompares = 0;
   int     bad = 0;
   int     last_pulse = -1;

   function automatic void heap_insert(input int v);
      int p = 0;
      while (p < hq.size() && hq[p] <= v) p++;
      hq.insert(p, v);
   endfunction

   function automatic bit outs_zero();
      return o_req_ready === '0 && o_rsp_valid === 1'b0 && o_rsp_id === '0 &&
             o_rsp_data === '0 && o_rsp_err === 1'b0 && o_heap_wrt === 1'b0 &&
             o_heap_read === 1'b0 && o_heap_data === '0;
   endfunction

   // Heap flags follow the model one edge later, like a registered heap.
   always @(posedge CLK) begin
      cyc          <= cyc + 1;
      i_heap_full  <= (hq.size() == CAP);
      i_heap_empty <= (hq.size() == 0);
      i_heap_data  <= (hq.size() != 0) ? DW'(hq[0]) : '0;
   end

   always @(negedge CLK) begin : mon
      logic [1:0]    op;
      logic [DW-1:0] key;
      exp_t          e;
      if (!RSTn) begin
         last_pulse = -1;
      end else begin
         if (o_req_ready !== '0 && o_rsp_valid) bad++;
         if ($countones(o_req_ready) > 1) bad++;
         for (int i = 0; i < NR; i++) begin
            if (o_req_ready[i] && i_req_valid[i]) begin
               glog.push_back('{cyc, i});
               op  = i_req_op[2*i +: 2];
               key = i_req_data[DW*i +: DW];
               e.id = i; e.data = '0; e.err = 1'b0;
               case (op)
                  2'b01: e.err = (hq.size() == CAP);
                  2'b10: if (hq.size() == 0) e.err = 1'b1; else e.data = DW'(hq[0]);
                  2'b11: if (hq.size() != 0) e.data = DW'(hq[0]);
                  default: e.err = 1'b1;
               endcase
               sb.push_back(e);
            end
         end
         if (o_heap_wrt || o_heap_read) begin
            if (last_pulse >= 0 && cyc - last_pulse < 3 + GAP) bad++;
            last_pulse = cyc;
            plog.push_back('{cyc, o_heap_wrt, o_heap_read, o_heap_data});
            if (o_heap_read && hq.size() != 0) void'(hq.pop_front());
            if (o_heap_wrt) heap_insert(int'(o_heap_data));
         end
         if (o_rsp_valid && i_rsp_ready) begin
            rlog.push_back(cyc);
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL rsp_unexpected: got id=%0d data=%h err=%b, want no response",
                        o_rsp_id, o_rsp_data, o_rsp_err);
            end else begin
               e = sb.pop_front();
               if (o_rsp_id !== 2'(e.id) || o_rsp_data !== e.data || o_rsp_err !== e.err) begin
                  miscompares++;
                  $display("FAIL rsp_fields: got id=%0d data=%h err=%b, want id=%0d data=%h err=%b",
                           o_rsp_id, o_rsp_data, o_rsp_err, e.id, e.data, e.err);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] d);
      i_req_op[2*i +: 2]   = op;
      i_req_data[DW*i +: DW] = d;
      i_req_valid[i]       = 1'b1;
   endtask

   task automatic wait_grants(input int n, input int budget, output bit ok);
      ok = 1'b0;
      repeat (budget) begin
         @(negedge CLK); #1;
         if (glog.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic issue(input int i, input logic [1:0] op, input logic [DW-1:0] d, output bit ok);
      int n = glog.size() + 1;
      set_req(i, op, d);
      wait_grants(n, 60, ok);
      tick();
      i_req_valid[i] = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit ok = 1'b0;
      repeat (80) begin
         @(negedge CLK); #1;
         if (sb.size() == 0) begin ok = 1'b1; break; end
      end
      repeat (GAP + 2) tick();
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s_drain: got %0d pending responses, want 0", name, sb.size());
      end
   endtask

   task automatic apply_reset();
      RSTn = 1'b0;
      sb.delete();
      repeat (3) tick();
      RSTn = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      i_req_valid = '1;
      repeat (3) @(negedge CLK);
      vectors++;
      if (!outs_zero()) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d d=%h e=%b w=%b r=%b hd=%h, want 0",
                  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err,
                  o_heap_wrt, o_heap_read, o_heap_data);
      end
      i_req_valid = '0;
      tick();
      RSTn = 1'b1;
      tick();
   endtask

   task automatic test_pop_empty();
      bit ok1, ok2;
      int bg = glog.size(), bp = plog.size(), br = rlog.size();
      set_req(2, 2'b10, '0);
      set_req(3, 2'b10, '0);
      wait_grants(bg + 1, 30, ok1);
      tick();
      i_req_valid[2] = 1'b0;
      wait_grants(bg + 2, 30, ok2);
      tick();
      i_req_valid[3] = 1'b0;
      wait_drain("t2");
      vectors++;
      if (!ok1 || !ok2 || glog[bg].id !== 2 || glog[bg+1].id !== 3) begin
         miscompares++;
         $display("FAIL t2_order: got ids %0d,%0d, want 2,3", glog[bg].id, glog[bg+1].id);
      end
      vectors++;
      if (plog.size() != bp) begin
         miscompares++;
         $display("FAIL t2_no_pulse: got %0d pulses, want 0", plog.size() - bp);
      end
      vectors++;
      if (glog[bg+1].cyc != rlog[br] + 1) begin
         miscompares++;
         $display("FAIL t2_skip_gap: got next grant at %0d, want %0d",
                  glog[bg+1].cyc, rlog[br] + 1);
      end
   endtask

   task automatic test_push();
      bit ok;
      int bg = glog.size(), bp = plog.size(), br = rlog.size();
      issue(0, 2'b01, 16'h0030, ok);
      wait_drain("t1");
      vectors++;
      if (!ok || plog.size() != bp + 1) begin
         miscompares++;
         $display("FAIL t1_pulse_count: got %0d, want 1", plog.size() - bp);
      end
      vectors++;
      if (plog[bp].cyc != glog[bg].cyc + 1 || plog[bp].wrt !== 1'b1 || plog[bp].rd !== 1'b0 ||
          plog[bp].data !== 16'h0030) begin
         miscompares++;
         $display("FAIL t1_pulse: got cyc=%0d w=%b r=%b d=%h, want cyc=%0d w=1 r=0 d=0030",
                  plog[bp].cyc, plog[bp].wrt, plog[bp].rd, plog[bp].data, glog[bg].cyc + 1);
      end
      vectors++;
      if (rlog[br] != glog[bg].cyc + 2) begin
         miscompares++;
         $display("FAIL t1_latency: got rsp at %0d, want %0d", rlog[br], glog[bg].cyc + 2);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int bg, bp;
      apply_reset();
      bg = glog.size();
      bp = plog.size();
      for (int i = 0; i < NR; i++) set_req(i, 2'b01, DW'(16'h0100 + i));
      wait_grants(bg + 5, 200, ok);
      tick();
      i_req_valid = '0;
      wait_drain("t3");
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL t3_grants: got %0d grants, want 5", glog.size() - bg);
      end
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (glog[bg+k].id !== k % NR || plog[bp+k].data !== DW'(16'h0100 + k % NR)) begin
            miscompares++;
            $display("FAIL t3_order%0d: got id=%0d d=%h, want id=%0d d=%h", k, glog[bg+k].id,
                     plog[bp+k].data, k % NR, DW'(16'h0100 + k % NR));
         end
      end
      for (int k = 1; k < 5; k++) begin
         vectors++;
         if (plog[bp+k].cyc - plog[bp+k-1].cyc != 3 + GAP) begin
            miscompares++;
            $display("FAIL t3_spacing%0d: got %0d cycles, want %0d", k,
                     plog[bp+k].cyc - plog[bp+k-1].cyc, 3 + GAP);
         end
      end
   endtask

   task automatic test_replace();
      bit ok;
      int bp = plog.size();
      hq.delete();
      hq.push_back(16'h0055);
      repeat (2) tick();
      issue(1, 2'b11, 16'h0010, ok);
      wait_drain("t4");
      vectors++;
      if (!ok || plog[bp].wrt !== 1'b1 || plog[bp].rd !== 1'b1 || plog[bp].data !== 16'h0010) begin
         miscompares++;
         $display("FAIL t4_pulse: got w=%b r=%b d=%h, want w=1 r=1 d=0010",
                  plog[bp].wrt, plog[bp].rd, plog[bp].data);
      end
      hq.delete();
      repeat (2) tick();
      issue(2, 2'b11, 16'h0077, ok);
      wait_drain("t4e");
      vectors++;
      if (!ok || plog[bp+1].wrt !== 1'b1 || plog[bp+1].rd !== 1'b0 ||
          plog[bp+1].data !== 16'h0077) begin
         miscompares++;
         $display("FAIL t4_replace_empty: got w=%b r=%b d=%h, want w=1 r=0 d=0077",
                  plog[bp+1].wrt, plog[bp+1].rd, plog[bp+1].data);
      end
      issue(3, 2'b00, 16'h0099, ok);
      wait_drain("t4i");
      vectors++;
      if (!ok || plog.size() != bp + 2) begin
         miscompares++;
         $display("FAIL t4_illegal: got %0d pulses, want 2", plog.size() - bp);
      end
   endtask

   task automatic test_full();
      bit ok1, ok2;
      int bp = plog.size();
      hq.delete();
      for (int i = 0; i < CAP; i++) hq.push_back(i + 1);
      repeat (2) tick();
      issue(0, 2'b01, 16'h0005, ok1);
      wait_drain("tf_push");
      vectors++;
      if (!ok1 || plog.size() != bp) begin
         miscompares++;
         $display("FAIL full_push: got %0d pulses, want 0", plog.size() - bp);
      end
      issue(1, 2'b10, '0, ok2);
      wait_drain("tf_pop");
      vectors++;
      if (!ok2 || plog[bp].rd !== 1'b1 || plog[bp].wrt !== 1'b0) begin
         miscompares++;
         $display("FAIL full_pop: got w=%b r=%b, want w=0 r=1", plog[bp].wrt, plog[bp].rd);
      end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, seen;
      int bg = glog.size(), bp = plog.size(), br = rlog.size();
      i_rsp_ready = 1'b0;
      set_req(0, 2'b01, 16'h0044);
      set_req(1, 2'b01, 16'h0045);
      wait_grants(bg + 1, 30, ok1);
      tick();
      i_req_valid[0] = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge CLK); #1;
         if (o_rsp_valid) begin seen = 1'b1; break; end
      end
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge CLK);
         vectors++;
         if (!seen || o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_data !== '0 ||
             o_rsp_err !== 1'b0 || o_req_ready !== '0 || plog.size() != bp + 1) begin
            miscompares++;
            $display("FAIL t5_hold%0d: got v=%b id=%0d d=%h e=%b rdy=%b np=%0d, want 1 0 0 0 0 1",
                     k, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err, o_req_ready,
                     plog.size() - bp);
         end
      end
      tick();
      i_rsp_ready = 1'b1;
      wait_grants(bg + 2, 30, ok2);
      tick();
      i_req_valid[1] = 1'b0;
      wait_drain("t5");
      vectors++;
      if (!ok1 || !ok2 || glog[bg+1].id !== 1 || glog[bg+1].cyc != rlog[br] + 1 + GAP) begin
         miscompares++;
         $display("FAIL t5_release: got id=%0d at %0d, want id=1 at %0d",
                  glog[bg+1].id, glog[bg+1].cyc, rlog[br] + 1 + GAP);
      end
   endtask

   task automatic reset_and_regrant(input string name);
      bit ok;
      int bg;
      set_req(0, 2'b10, '0);
      set_req(3, 2'b10, '0);
      #1 RSTn = 1'b0;
      sb.delete();
      #1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge CLK);
         vectors++;
         if (!outs_zero()) begin
            miscompares++;
            $display("FAIL %s_outs%0d: got rdy=%b rv=%b w=%b r=%b hd=%h id=%0d d=%h, want 0",
                     name, k, o_req_ready, o_rsp_valid, o_heap_wrt, o_heap_read, o_heap_data,
                     o_rsp_id, o_rsp_data);
         end
      end
      i_rsp_ready = 1'b1;
      bg = glog.size();
      tick();
      RSTn = 1'b1;
      wait_grants(bg + 1, 20, ok);
      tick();
      i_req_valid = '0;
      vectors++;
      if (!ok || glog[bg].id !== 0) begin
         miscompares++;
         $display("FAIL %s_first_grant: got id=%0d ok=%b, want id=0", name, glog[bg].id, ok);
      end
      wait_drain(name);
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      int br;
      i_rsp_ready = 1'b0;
      issue(2, 2'b10, '0, ok);
      tick();
      @(negedge CLK);
      vectors++;
      if (!ok || o_rsp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL t6_in_resp: got rsp_valid=%b, want 1", o_rsp_valid);
      end
      reset_and_regrant("t6_resp");
      br = rlog.size();
      issue(2, 2'b01, 16'h0066, ok);
      repeat (20) begin
         @(negedge CLK); #1;
         if (rlog.size() > br) break;
      end
      vectors++;
      if (!ok || rlog.size() <= br) begin
         miscompares++;
         $display("FAIL t6_gap_setup: got %0d responses, want 1", rlog.size() - br);
      end
      tick();
      tick();
      reset_and_regrant("t6_gap");
   endtask

   task automatic test_invariants();
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL invariants: got %0d violations, want 0", bad);
      end
   endtask

   initial begin
      RSTn        = 1'b0;
      i_req_valid = '0;
      i_req_op    = '0;
      i_req_data  = '0;
      i_rsp_ready = 1'b1;
      test_reset();
      test_pop_empty();
      test_push();
      test_round_robin();
      test_replace();
      test_full();
      test_backpressure();
      test_reset_mid_op();
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
